// File: rtl/cache_req_arbiter_pkg.sv
// Shared types and default widths for the cache request arbiter.
package cache_arb_pkg;

   localparam int unsigned DEF_NUM_REQ        = 4;
   localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/cache_req_arbiter_rr.sv
// Combinational round-robin picker: lowest requester above last_grant, wrapping.
module rr_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] mask;
   logic                 hit;

   // Upper copy of the request vector supplies the wrap-around candidates.
   always_comb begin
      req_dbl = {req, req};
      mask    = '0;
      for (int unsigned i = 0; i < 2*NUM_REQ; i++) begin
         mask[i] = (i > 32'(last_grant));
      end
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      hit       = 1'b0;
      for (int unsigned i = 0; i < 2*NUM_REQ; i++) begin
         if (!hit && req_dbl[i] && mask[i]) begin
            hit = 1'b1;
            if (i >= NUM_REQ) begin
               grant[i-NUM_REQ] = 1'b1;
               grant_idx        = ID_WIDTH'(i - NUM_REQ);
            end else begin
               grant[i]  = 1'b1;
               grant_idx = ID_WIDTH'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the cache request port; one transaction at a time.
// Optional watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
   parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_err,
   output logic                          cache_req,
   output logic                          cache_we,
   output logic [ADDRESS_WIDTH-1:0]      cache_addr,
   output logic [DATA_WIDTH-1:0]         cache_wdata,
   input  logic                          cache_done,
   input  logic [DATA_WIDTH-1:0]         cache_rdata,
   output logic                          busy,
   output logic [ID_WIDTH-1:0]           grant_id
);

   arb_state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]       last_grant_q, last_grant_d;
   logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
   logic                      we_q, we_d;
   logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [NUM_REQ-1:0]        arb_grant;
   logic [ID_WIDTH-1:0]       arb_idx;
   logic                      timeout_hit;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

`ifdef CACHE_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign resp_err    = err_q;

   // cache_done takes priority over the limit when both land in one cycle.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == WAIT) begin
         if (cache_done) begin
            err_d = 1'b0;
         end else if (timeout_hit) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign resp_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req_valid) state_d = WAIT;
         WAIT:    if (cache_done || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      if (state_q == IDLE && |req_valid) begin
         last_grant_d = arb_idx;
         grant_id_d   = arb_idx;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
               we_d    = req_we[i];
               addr_d  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
               wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      if (state_q == WAIT) begin
         if (cache_done) begin
            rdata_d = we_q ? '0 : cache_rdata;
         end else if (timeout_hit) begin
            rdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
         grant_id_q   <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (state_q == IDLE && !reset) begin
         req_ready = arb_grant;
      end
      if (state_q == RESP) begin
         resp_valid[grant_id_q] = 1'b1;
      end
      cache_req = (state_q == WAIT);
      busy      = (state_q != IDLE);
   end

   assign cache_we    = we_q;
   assign cache_addr  = addr_q;
   assign cache_wdata = wdata_q;
   assign resp_rdata  = rdata_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a response scoreboard.
module tb_cache_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid, req_we, req_ready, resp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [DW-1:0]     resp_rdata, cache_wdata, cache_rdata;
   logic              resp_err, cache_req, cache_we, cache_done, busy;
   logic [AW-1:0]     cache_addr;
   logic [IW-1:0]     grant_id;

   always #5 clk = ~clk;

   cache_req_arbiter #(
      .NUM_REQ        (N),
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .cache_req   (cache_req),
      .cache_we    (cache_we),
      .cache_addr  (cache_addr),
      .cache_wdata (cache_wdata),
      .cache_done  (cache_done),
      .cache_rdata (cache_rdata),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   typedef struct {
      logic [N-1:0]  onehot;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void expect_resp(int id, logic [DW-1:0] rd, logic err);
      exp_t e;
      e.onehot = N'(1 << id);
      e.rdata  = rd;
      e.err    = err;
      sb.push_back(e);
   endfunction

   function automatic void set_req(int id, logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
      req_valid[id]             = v;
      req_we[id]                = we;
      req_addr[id*AW +: AW]     = a;
      req_wdata[id*DW +: DW]    = wd;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (resp_valid !== '0) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", 64'(resp_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_valid", 64'(resp_valid), 64'(mon_e.onehot));
            chk("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
            chk("resp_err",   64'(resp_err),   64'(mon_e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [N-1:0] t2_ready [15];

   initial begin
      t2_ready = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                   4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                   4'b0001, 4'b0000, 4'b0000};
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      cache_done = 1'b0; cache_rdata = '0;
      step(); step();
      reset = 1'b0;

      // Reset state
      at_neg();
      chk("rst_busy",       64'(busy), 64'd0);
      chk("rst_cache_req",  64'(cache_req), 64'd0);
      chk("rst_req_ready",  64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_grant_id",   64'(grant_id), 64'd0);
      chk("rst_cache_addr", 64'(cache_addr), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("rst_resp_err",   64'(resp_err), 64'd0);

      // T1: requester 2 reads 0x40, done in cycle 3
      step(); set_req(2, 1'b1, 1'b0, 32'h40, 32'h0);
      at_neg(); chk("t1_ready", 64'(req_ready), 64'b0100);
      step(); req_valid = '0;
      at_neg();
      chk("t1_cache_req",  64'(cache_req), 64'd1);
      chk("t1_cache_addr", 64'(cache_addr), 64'h40);
      chk("t1_cache_we",   64'(cache_we), 64'd0);
      chk("t1_grant_id",   64'(grant_id), 64'd2);
      chk("t1_busy",       64'(busy), 64'd1);
      step();
      step(); cache_done = 1'b1; cache_rdata = 32'hDEADBEEF;
      expect_resp(2, 32'hDEADBEEF, 1'b0);
      at_neg();
      chk("t1_req_in_done_cycle", 64'(cache_req), 64'd1);
      chk("t1_no_early_resp",     64'(resp_valid), 64'd0);
      step(); cache_done = 1'b0; cache_rdata = '0;
      at_neg(); chk("t1_resp_timing", 64'(resp_valid), 64'b0100);
      step();

      // T2: all four assert from reset, cache completes immediately
      reset = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h1000 + 32'(i*16), 32'h0);
      cache_done = 1'b1;
      step(); reset = 1'b0;
      expect_resp(0, 32'hA000_0001, 1'b0);
      expect_resp(1, 32'hA000_0004, 1'b0);
      expect_resp(2, 32'hA000_0007, 1'b0);
      expect_resp(3, 32'hA000_000A, 1'b0);
      expect_resp(0, 32'hA000_000D, 1'b0);
      for (int c = 0; c < 15; c++) begin
         cache_rdata = 32'hA000_0000 | 32'(c);
         if (c == 13) req_valid = '0;
         at_neg();
         chk($sformatf("t2_ready_c%0d", c), 64'(req_ready), 64'(t2_ready[c]));
         if (c % 3 == 1) chk($sformatf("t2_addr_c%0d", c), 64'(cache_addr),
                             64'(32'h1000 + 32'((((c - 1) / 3) % 4) * 16)));
         step();
      end
      cache_done = 1'b0;

      // T3: requester 1 writes 0x12345678 to 0x100, 5 WAIT cycles
      set_req(1, 1'b1, 1'b1, 32'h100, 32'h12345678);
      at_neg(); chk("t3_ready", 64'(req_ready), 64'b0010);
      step(); req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int w = 1; w <= 5; w++) begin
         if (w == 5) begin
            cache_done = 1'b1; cache_rdata = '1;
            expect_resp(1, 32'h0, 1'b0);
         end
         at_neg();
         chk($sformatf("t3_req_w%0d", w),   64'(cache_req), 64'd1);
         chk($sformatf("t3_we_w%0d", w),    64'(cache_we), 64'd1);
         chk($sformatf("t3_wdata_w%0d", w), 64'(cache_wdata), 64'h12345678);
         chk($sformatf("t3_addr_w%0d", w),  64'(cache_addr), 64'h100);
         step();
      end
      cache_done = 1'b0;
      at_neg(); chk("t3_resp_timing", 64'(resp_valid), 64'b0010);
      step();

      // T4: reset two cycles into WAIT, then round-robin restarts at 0
      set_req(1, 1'b1, 1'b0, 32'h200, 32'h0);
      at_neg(); chk("t4_ready", 64'(req_ready), 64'b0010);
      step(); req_valid = '0;
      step();
      step(); reset = 1'b1; cache_done = 1'b1; cache_rdata = 32'h5555;
      step(); reset = 1'b0; cache_done = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
      set_req(2, 1'b1, 1'b0, 32'h400, 32'h0);
      at_neg();
      chk("t4_busy_after_rst",  64'(busy), 64'd0);
      chk("t4_req_after_rst",   64'(cache_req), 64'd0);
      chk("t4_regrant_0",       64'(req_ready), 64'b0001);
      step(); req_valid[0] = 1'b0; cache_done = 1'b1; cache_rdata = 32'h11111111;
      expect_resp(0, 32'h11111111, 1'b0);
      at_neg(); chk("t4_addr0", 64'(cache_addr), 64'h300);
      step();
      at_neg(); chk("t4_resp0", 64'(resp_valid), 64'b0001);
      step();
      at_neg(); chk("t4_ready2", 64'(req_ready), 64'b0100);
      step(); req_valid[2] = 1'b0; cache_rdata = 32'h22222222;
      expect_resp(2, 32'h22222222, 1'b0);
      at_neg(); chk("t4_addr2", 64'(cache_addr), 64'h400);
      step(); cache_done = 1'b0;
      at_neg(); chk("t4_resp2", 64'(resp_valid), 64'b0100);
      step();

`ifdef CACHE_ARB_TIMEOUT_EN
      // T5: no cache_done, watchdog fires 8 cycles after WAIT entry
      set_req(3, 1'b1, 1'b0, 32'h500, 32'h0);
      at_neg(); chk("t5_ready", 64'(req_ready), 64'b1000);
      step(); req_valid = '0;
      expect_resp(3, 32'h0, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         at_neg();
         if (c == 8) begin
            chk("t5_busy_c8", 64'(busy), 64'd1);
            chk("t5_no_resp_c8", 64'(resp_valid), 64'd0);
         end
         step();
      end
      at_neg(); chk("t5_resp_timing", 64'(resp_valid), 64'b1000);
      step();

      // T6: cache_done in the limit cycle wins
      set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
      at_neg(); chk("t6_ready", 64'(req_ready), 64'b0001);
      step(); req_valid = '0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin
            cache_done = 1'b1; cache_rdata = 32'hCAFEF00D;
            expect_resp(0, 32'hCAFEF00D, 1'b0);
         end
         at_neg();
         step();
      end
      cache_done = 1'b0;
      at_neg(); chk("t6_resp_timing", 64'(resp_valid), 64'b0001);
      step();
`endif

      step(); step();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
